// File: rtl/word32_8bits_pkg.sv
// Shared widths, constants and the byte-lane selector for the 32-bit to 8-bit serializer.
package word32_8bits_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 2;

  localparam logic [BYTE_W-1:0] IDLE_DATA_DFLT = 8'h00;
  localparam logic [CNT_W-1:0]  CNT_FIRST      = 2'd0;
  localparam logic [CNT_W-1:0]  CNT_ONE        = 2'd1;
  localparam logic [CNT_W-1:0]  CNT_LAST       = 2'd3;

  // Byte k of a word in transmit order; MSB-first walks lanes 3,2,1,0.
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                  input logic [CNT_W-1:0]  idx,
                                                  input logic              msb_first);
    logic [CNT_W-1:0] lane;
    lane = msb_first ? (CNT_LAST - idx) : idx;
    return word[{lane, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/word32_8bits_shift.sv
// Shift stage: owns the word being transmitted, the byte index and the registered byte outputs.
module word32_8bits_shift
  import word32_8bits_pkg::*;
#(
  parameter logic              MSB_FIRST = 1'b1,
  parameter logic [BYTE_W-1:0] IDLE_DATA = IDLE_DATA_DFLT
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_word_i,
  output logic              busy_o,
  output logic              last_o,
  output logic              valid_o,
  output logic [BYTE_W-1:0] data_o,
  output logic              sof_o
);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              sof_q, sof_d;

  // Next byte selection, index advance and reload on the final byte.
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    data_d  = IDLE_DATA;
    sof_d   = 1'b0;
    if (busy_q) begin
      valid_d = 1'b1;
      data_d  = pick_byte(sr_q, cnt_q, MSB_FIRST);
      sof_d   = (cnt_q == CNT_FIRST);
      if (cnt_q == CNT_LAST) begin
        cnt_d = CNT_FIRST;
        if (load_i) begin
          sr_d   = load_word_i;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_FIRST;
      if (load_i) begin
        sr_d   = load_word_i;
        busy_d = 1'b1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  // Serializer state and output registers.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      sr_q    <= {WORD_W{1'b0}};
      cnt_q   <= CNT_FIRST;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= IDLE_DATA;
      sof_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
    end
  end

  assign busy_o  = busy_q;
  assign last_o  = busy_q & (cnt_q == CNT_LAST);
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sof_o   = sof_q;

endmodule

// File: rtl/word32_8bits.sv
// 32-bit word to byte-stream converter: a holding register with valid/ready intake feeding the shift stage.
module word32_8bits
  import word32_8bits_pkg::*;
#(
  parameter logic              MSB_FIRST = 1'b1,
  parameter logic [BYTE_W-1:0] IDLE_DATA = IDLE_DATA_DFLT
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [WORD_W-1:0] Data_in,
  output logic              ready_in,
  output logic              valid_out,
  output logic [BYTE_W-1:0] data_out,
  output logic              sof_out
);

  logic [WORD_W-1:0] hr_q, hr_d;
  logic              hold_full_q, hold_full_d;
  logic              accept_s;
  logic              load_s;
  logic              busy_s;
  logic              last_s;

  // Loading needs a full holding register and accepting needs an empty one, so they never coincide.
  assign accept_s = valid_in & ~hold_full_q;
  assign load_s   = hold_full_q & (~busy_s | last_s);
  assign ready_in = ~hold_full_q;

  // Holding register fill on accept, drain on transfer to the shift stage.
  always_comb begin
    hr_d        = hr_q;
    hold_full_d = hold_full_q;
    if (load_s) begin
      hold_full_d = 1'b0;
    end else if (accept_s) begin
      hr_d        = Data_in;
      hold_full_d = 1'b1;
    end else begin
      hold_full_d = hold_full_q;
    end
  end

  // Holding register state.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      hr_q        <= {WORD_W{1'b0}};
      hold_full_q <= 1'b0;
    end else begin
      hr_q        <= hr_d;
      hold_full_q <= hold_full_d;
    end
  end

  word32_8bits_shift #(
    .MSB_FIRST(MSB_FIRST),
    .IDLE_DATA(IDLE_DATA)
  ) u_shift (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .load_i     (load_s),
    .load_word_i(hr_q),
    .busy_o     (busy_s),
    .last_o     (last_s),
    .valid_o    (valid_out),
    .data_o     (data_out),
    .sof_o      (sof_out)
  );

endmodule
